// File: rtl/mem_access_unit.sv
// Memory-stage access unit: turns the M-stage load/store into an SRAM-like
// request/response bus transaction, stalls the pipe while it is in flight,
// and formats store strobes/data and load results.
module mem_access_unit #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  memenM,
   input  logic                  memwriteM,
   input  logic [1:0]            sizeM,
   input  logic                  unsignedM,
   input  logic [ADDR_W-1:0]     addrM,
   input  logic [DATA_W-1:0]     wdataM,
   input  logic                  flushM,
   input  logic                  stall_i,
   output logic                  stall_o,
   output logic [DATA_W-1:0]     rdataM_o,
   output logic                  adel_o,
   output logic                  ades_o,
   output logic                  data_req,
   output logic                  data_wr,
   output logic [1:0]            data_size,
   output logic [ADDR_W-1:0]     data_addr,
   output logic [DATA_W/8-1:0]   data_wstrb,
   output logic [DATA_W-1:0]     data_wdata,
   input  logic                  data_addr_ok,
   input  logic                  data_data_ok,
   input  logic [DATA_W-1:0]     data_rdata
);

   localparam int unsigned Lanes = DATA_W / 8;
   localparam int unsigned OffW  = $clog2(Lanes);

   typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} stateT;

   stateT               stateQ;
   logic                discardQ;
   logic [DATA_W-1:0]   heldQ;
   logic [ADDR_W-1:0]   addrQ;
   logic [1:0]          sizeQ;
   logic                wrQ;
   logic                unsQ;
   logic [Lanes-1:0]    strbQ;
   logic [DATA_W-1:0]   wdataQ;

   logic                misal;
   logic                start;
   logic [Lanes-1:0]    mask;
   logic [Lanes-1:0]    strbNew;
   logic [DATA_W-1:0]   wdataNew;
   logic [DATA_W-1:0]   shifted;
   logic [DATA_W-1:0]   ext;
   logic                deliver;

   // Decode the incoming access: alignment check, byte strobes, replicated store data
   always_comb begin
      misal    = 1'b0;
      mask     = '0;
      wdataNew = wdataM;
      unique case (sizeM)
         2'b00: begin
            mask[0]  = 1'b1;
            wdataNew = {Lanes{wdataM[7:0]}};
         end
         2'b01: begin
            misal      = addrM[0];
            mask[1:0]  = 2'b11;
            wdataNew   = {(Lanes / 2){wdataM[15:0]}};
         end
         2'b10: begin
            misal      = |addrM[1:0];
            mask[3:0]  = 4'hF;
            wdataNew   = {(Lanes / 4){wdataM[31:0]}};
         end
         default: begin
            // Doubleword only exists on a 64-bit bus
            misal    = (DATA_W == 64) ? |addrM[OffW-1:0] : 1'b1;
            mask     = '1;
            wdataNew = wdataM;
         end
      endcase
      strbNew = memwriteM ? (mask << addrM[OffW-1:0]) : '0;
   end

   assign start  = memenM & ~misal & ~flushM & (stateQ == StIdle) & rst;
   assign adel_o = memenM & ~memwriteM & misal;
   assign ades_o = memenM & memwriteM & misal;

   // Align and extend the returned load data using the latched access shape
   always_comb begin
      shifted = data_rdata >> {addrQ[OffW-1:0], 3'b000};
      ext     = shifted;
      unique case (sizeQ)
         2'b00:   ext = unsQ ? DATA_W'(shifted[7:0]) : DATA_W'($signed(shifted[7:0]));
         2'b01:   ext = unsQ ? DATA_W'(shifted[15:0]) : DATA_W'($signed(shifted[15:0]));
         2'b10:   ext = ((DATA_W == 64) && unsQ) ? DATA_W'(shifted[31:0])
                                                 : DATA_W'($signed(shifted[31:0]));
         default: ext = shifted;
      endcase
   end

   assign deliver  = (stateQ == StWait) & data_data_ok & ~discardQ;
   assign rdataM_o = deliver ? ext : heldQ;

   assign stall_o  = start | (stateQ == StReq) | ((stateQ == StWait) & ~deliver);

   // Bus request is driven live in the start cycle, from the latches while retrying
   assign data_req   = start | (stateQ == StReq);
   assign data_wr    = start ? memwriteM : ((stateQ == StReq) & wrQ);
   assign data_size  = (stateQ == StIdle) ? sizeM : sizeQ;
   assign data_addr  = (stateQ == StIdle) ? addrM : addrQ;
   assign data_wstrb = start ? strbNew : ((stateQ == StReq) ? strbQ : '0);
   assign data_wdata = (stateQ == StIdle) ? wdataNew : wdataQ;

   // Transaction FSM, request latches, flush-discard flag and held load result
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stateQ   <= StIdle;
         discardQ <= 1'b0;
         heldQ    <= '0;
         addrQ    <= '0;
         sizeQ    <= '0;
         wrQ      <= 1'b0;
         unsQ     <= 1'b0;
         strbQ    <= '0;
         wdataQ   <= '0;
      end else begin
         unique case (stateQ)
            StIdle: begin
               if (start) begin
                  addrQ    <= addrM;
                  sizeQ    <= sizeM;
                  wrQ      <= memwriteM;
                  unsQ     <= unsignedM;
                  strbQ    <= strbNew;
                  wdataQ   <= wdataNew;
                  discardQ <= 1'b0;
                  stateQ   <= data_addr_ok ? StWait : StReq;
               end
            end
            StReq: begin
               // The request is never withdrawn; a flush only marks the result dead
               if (flushM) discardQ <= 1'b1;
               if (data_addr_ok) stateQ <= StWait;
            end
            StWait: begin
               if (data_data_ok) begin
                  discardQ <= 1'b0;
                  if (!discardQ && stall_i) begin
                     stateQ <= StDone;
                     if (!wrQ) heldQ <= ext;
                  end else begin
                     stateQ <= StIdle;
                  end
               end else if (flushM) begin
                  discardQ <= 1'b1;
               end
            end
            StDone: begin
               if (!stall_i) stateQ <= StIdle;
            end
            default: stateQ <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed and randomized accesses against a
// behavioural bus slave and an arithmetic model of strobes, data and loads.
module tb_mem_access_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        memenM, memwriteM, unsignedM, flushM, stall_i;
   logic [1:0]  sizeM;
   logic [31:0] addrM, wdataM;
   logic        stall_o, adel_o, ades_o, data_req, data_wr;
   logic [31:0] rdataM_o, data_addr, data_wdata, data_rdata;
   logic [1:0]  data_size;
   logic [3:0]  data_wstrb;
   logic        data_addr_ok, data_data_ok;

   mem_access_unit #(.DATA_W(32), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .memenM(memenM), .memwriteM(memwriteM), .sizeM(sizeM),
      .unsignedM(unsignedM), .addrM(addrM), .wdataM(wdataM), .flushM(flushM),
      .stall_i(stall_i), .stall_o(stall_o), .rdataM_o(rdataM_o), .adel_o(adel_o),
      .ades_o(ades_o), .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
   );

   logic        memen64, memwrite64, unsigned64;
   logic [1:0]  size64;
   logic [31:0] addr64;
   logic [63:0] wdata64, rdataOut64, wdataOut64, rdata64;
   logic        stallOut64, adel64, ades64, req64, wr64, addrOk64, dataOk64;
   logic [1:0]  sizeOut64;
   logic [31:0] addrOut64;
   logic [7:0]  wstrb64;

   mem_access_unit #(.DATA_W(64), .ADDR_W(32)) dut64 (
      .clk(clk), .rst(rst), .memenM(memen64), .memwriteM(memwrite64), .sizeM(size64),
      .unsignedM(unsigned64), .addrM(addr64), .wdataM(wdata64), .flushM(1'b0),
      .stall_i(1'b0), .stall_o(stallOut64), .rdataM_o(rdataOut64), .adel_o(adel64),
      .ades_o(ades64), .data_req(req64), .data_wr(wr64), .data_size(sizeOut64),
      .data_addr(addrOut64), .data_wstrb(wstrb64), .data_wdata(wdataOut64),
      .data_addr_ok(addrOk64), .data_data_ok(dataOk64), .data_rdata(rdata64)
   );

   int nCmp = 0;
   int nBad = 0;
   logic [31:0] heldM;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nCmp++;
      assert (obs === exp) else begin
         nBad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Load result: pick the addressed bytes, then sign/zero extend to the bus width
   function automatic logic [63:0] expLoad(input int w, input logic [1:0] sz, input bit uns,
                                           input int off, input logic [63:0] rd);
      int nb;
      logic [63:0] v, m;
      nb = 1 << sz;
      v  = rd >> (8 * off);
      m  = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
      v  = v & m;
      if (!uns && (8 * nb < w) && (((v >> (8 * nb - 1)) & 64'd1) != 64'd0)) v = v | ~m;
      if (w == 32) v = v & 64'hFFFF_FFFF;
      return v;
   endfunction

   function automatic logic [63:0] expStrb(input int w, input logic [1:0] sz, input int off);
      int nb;
      nb = 1 << sz;
      return (((64'd1 << nb) - 64'd1) << off) & ((64'd1 << (w / 8)) - 64'd1);
   endfunction

   function automatic logic [63:0] expWdata(input int w, input logic [1:0] sz,
                                            input logic [63:0] wd);
      int nb;
      logic [63:0] v;
      nb = 1 << sz;
      v  = 64'd0;
      for (int i = 0; i < w / 8; i++) v = v | (((wd >> (8 * (i % nb))) & 64'hFF) << (8 * i));
      return v;
   endfunction

   task automatic idle();
      memenM = 1'b0; memwriteM = 1'b0; flushM = 1'b0; stall_i = 1'b0;
      data_addr_ok = 1'b0; data_data_ok = 1'b0;
   endtask

   // One access on the 32-bit unit with a scripted slave; checks every cycle
   task automatic doAccess(input bit wr, input logic [1:0] sz, input bit uns,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                           input int addrLat, input int dataLat, input int flushAt,
                           input int stallIn);
      int dataCyc, stallCyc;
      bit disc;
      logic [31:0] expR, expRd;
      dataCyc  = addrLat + dataLat;
      disc     = (flushAt >= 1) && (flushAt < dataCyc);
      stallCyc = disc ? 0 : stallIn;
      expR     = 32'(expLoad(32, sz, uns, int'(addr[1:0]), 64'(rd)));
      memenM = 1'b1; memwriteM = wr; sizeM = sz; unsignedM = uns; addrM = addr; wdataM = wd;
      for (int k = 0; k <= dataCyc + stallCyc; k++) begin
         data_addr_ok = (k == addrLat);
         data_data_ok = (k == dataCyc);
         data_rdata   = (k == dataCyc) ? rd : $urandom;
         flushM       = (k == flushAt) && disc;
         if (disc && k > flushAt) begin
            memenM = 1'b0; addrM = $urandom; wdataM = $urandom;
         end
         if (k < dataCyc) stall_i = 1'($urandom_range(0, 1));
         else stall_i = (k < dataCyc + stallCyc);
         @(negedge clk);
         chk("req", 64'(data_req), 64'(k <= addrLat));
         chk("stall", 64'(stall_o), 64'(disc ? (k <= dataCyc) : (k < dataCyc)));
         if (k <= addrLat) begin
            chk("addr", 64'(data_addr), 64'(addr));
            chk("size", 64'(data_size), 64'(sz));
            chk("wr", 64'(data_wr), 64'(wr));
            if (wr) begin
               chk("wstrb", 64'(data_wstrb), expStrb(32, sz, int'(addr[1:0])));
               chk("wdata", 64'(data_wdata), expWdata(32, sz, 64'(wd)));
            end
         end
         if (k == 0) chk("addrerr", 64'({adel_o, ades_o}), 64'd0);
         if (!(k == dataCyc && wr && !disc)) begin
            expRd = (k == dataCyc && !disc) ? expR : heldM;
            chk("rdata", 64'(rdataM_o), 64'(expRd));
         end
         if (k == dataCyc && !disc && !wr && stallCyc > 0) heldM = expR;
         @(posedge clk); #1;
      end
      idle();
   endtask

   task automatic doMisal(input bit wr, input logic [1:0] sz, input logic [31:0] addr);
      memenM = 1'b1; memwriteM = wr; sizeM = sz; addrM = addr; data_addr_ok = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("adel", 64'(adel_o), 64'(!wr));
         chk("ades", 64'(ades_o), 64'(wr));
         chk("misreq", 64'(data_req), 64'd0);
         chk("misstall", 64'(stall_o), 64'd0);
         chk("misrdata", 64'(rdataM_o), 64'(heldM));
         @(posedge clk); #1;
      end
      idle();
   endtask

   // 64-bit unit: immediate accept, response in the following cycle
   task automatic do64(input bit wr, input logic [1:0] sz, input bit uns, input logic [31:0] addr,
                       input logic [63:0] wd, input logic [63:0] rd);
      bit mis;
      mis = ((addr % (32'd1 << sz)) != 32'd0);
      memen64 = 1'b1; memwrite64 = wr; size64 = sz; unsigned64 = uns; addr64 = addr;
      wdata64 = wd; addrOk64 = 1'b1; dataOk64 = 1'b0;
      @(negedge clk);
      chk("d64 adel", 64'(adel64), 64'(mis && !wr));
      chk("d64 ades", 64'(ades64), 64'(mis && wr));
      chk("d64 req", 64'(req64), 64'(!mis));
      if (!mis && wr) begin
         chk("d64 wstrb", 64'(wstrb64), expStrb(64, sz, int'(addr[2:0])));
         chk("d64 wdata", wdataOut64, expWdata(64, sz, wd));
      end
      @(posedge clk); #1;
      memen64 = 1'b0; addrOk64 = 1'b0;
      if (!mis) begin
         dataOk64 = 1'b1; rdata64 = rd;
         @(negedge clk);
         if (!wr) chk("d64 rdata", rdataOut64, expLoad(64, sz, uns, int'(addr[2:0]), rd));
         chk("d64 stall", 64'(stallOut64), 64'd0);
         @(posedge clk); #1;
         dataOk64 = 1'b0;
      end
   endtask

   initial begin
      bit          wr;
      logic [1:0]  sz;
      logic [31:0] a;
      int          al, dl, fa;

      rst = 1'b0; heldM = 32'd0;
      idle();
      sizeM = 2'b00; unsignedM = 1'b0; addrM = 32'd0; wdataM = 32'd0; data_rdata = 32'd0;
      memen64 = 1'b0; memwrite64 = 1'b0; unsigned64 = 1'b0; size64 = 2'b00; addr64 = 32'd0;
      wdata64 = 64'd0; rdata64 = 64'd0; addrOk64 = 1'b0; dataOk64 = 1'b0;

      @(negedge clk);
      chk("rst req", 64'(data_req), 64'd0);
      chk("rst stall", 64'(stall_o), 64'd0);
      chk("rst rdata", 64'(rdataM_o), 64'd0);
      chk("rst wstrb", 64'(data_wstrb), 64'd0);
      chk("rst wr", 64'(data_wr), 64'd0);
      chk("rst rdata64", rdataOut64, 64'd0);
      @(posedge clk); #1;
      rst = 1'b1;

      // Directed loads, stores and misaligned accesses
      doAccess(1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 32'hDEADBEEF, 0, 3, 0, 0);
      doAccess(1'b0, 2'b00, 1'b0, 32'h103, 32'd0, 32'h80112233, 0, 1, 0, 0);
      doAccess(1'b0, 2'b00, 1'b1, 32'h103, 32'd0, 32'h80112233, 1, 2, 0, 0);
      doAccess(1'b0, 2'b01, 1'b0, 32'h102, 32'd0, 32'h7FFF0000, 0, 2, 0, 0);
      doAccess(1'b1, 2'b01, 1'b0, 32'h102, 32'h00001234, 32'd0, 2, 1, 0, 0);
      doMisal(1'b0, 2'b10, 32'h102);
      doMisal(1'b1, 2'b10, 32'h101);
      doMisal(1'b0, 2'b11, 32'h100);
      // Result held through a downstream stall, then a flushed access leaves it intact
      doAccess(1'b0, 2'b10, 1'b0, 32'h180, 32'd0, 32'hCAFEF00D, 0, 2, 0, 2);
      doAccess(1'b0, 2'b10, 1'b0, 32'h104, 32'd0, 32'h00000055, 3, 2, 1, 0);
      doAccess(1'b1, 2'b00, 1'b0, 32'h107, 32'h000000A5, 32'd0, 0, 1, 0, 1);

      // Reset while waiting for data: everything clears at once
      memenM = 1'b1; memwriteM = 1'b0; sizeM = 2'b10; addrM = 32'h200; data_addr_ok = 1'b1;
      @(negedge clk);
      chk("wait req", 64'(data_req), 64'd1);
      @(posedge clk); #1;
      data_addr_ok = 1'b0;
      @(negedge clk);
      chk("wait stall", 64'(stall_o), 64'd1);
      #1 rst = 1'b0;
      #1;
      chk("midrst req", 64'(data_req), 64'd0);
      chk("midrst stall", 64'(stall_o), 64'd0);
      chk("midrst rdata", 64'(rdataM_o), 64'd0);
      heldM = 32'd0;
      idle();
      @(posedge clk); #1;
      rst = 1'b1;

      // Randomized traffic, back to back
      for (int n = 0; n < 60; n++) begin
         wr = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0) begin
            sz = 2'($urandom_range(1, 2));
            a  = $urandom | 32'd1;
            doMisal(wr, sz, a);
         end else begin
            sz = 2'($urandom_range(0, 2));
            a  = $urandom & ~((32'd1 << sz) - 32'd1);
            al = $urandom_range(0, 3);
            dl = $urandom_range(1, 3);
            fa = 0;
            if (al + dl >= 2 && $urandom_range(0, 3) == 0) fa = $urandom_range(1, al + dl - 1);
            doAccess(wr, sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom, al, dl, fa,
                     $urandom_range(0, 2));
         end
      end

      // 64-bit bus
      do64(1'b1, 2'b11, 1'b0, 32'h8, {$urandom, $urandom}, 64'd0);
      do64(1'b1, 2'b10, 1'b0, 32'hC, 64'h0000_0000_1122_3344, 64'd0);
      do64(1'b1, 2'b00, 1'b0, 32'h5, 64'h0000_0000_0000_00C3, 64'd0);
      do64(1'b0, 2'b11, 1'b0, 32'h4, 64'd0, 64'd0);
      do64(1'b0, 2'b10, 1'b1, 32'hC, 64'd0, 64'h8765_4321_0000_0000);
      do64(1'b0, 2'b10, 1'b0, 32'hC, 64'd0, 64'h8765_4321_0000_0000);
      do64(1'b0, 2'b11, 1'b0, 32'h10, 64'd0, 64'hF00D_CAFE_1234_5678);
      do64(1'b0, 2'b01, 1'b0, 32'h6, 64'd0, 64'h9ABC_0000_0000_0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

endmodule
